// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/lap stopwatch controller: prescaled tick drives a chain of cascaded
// BCD digit counters, with a frozen lap display and a sticky overflow flag.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  running,
  output logic                  tick,
  output logic                  overflow
);
  localparam int CW    = 4 * DIGITS;
  localparam int PSC_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t            state, state_nxt;
  logic [PSC_W-1:0]  psc;
  logic [CW-1:0]     display_reg;
  logic [CW-1:0]     count_inc;
  logic              wrap;
  logic              lap_capture;
  logic              clear_all;

  // Ripple-carry BCD increment; MSB of the result is the carry out of the top digit.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  assign {wrap, count_inc} = bcd_inc(count);
  assign running = (state == RUN) || (state == LAP);
  assign tick    = running && (psc == PSC_W'(PRESCALE - 1));
  assign display = (state == LAP) ? display_reg : count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Commands that are meaningless in the current state do not mask lower ones.
  always_comb begin
    state_nxt   = state;
    lap_capture = 1'b0;
    clear_all   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (lap) begin
          state_nxt   = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (stop)     state_nxt = PAUSE;
        else if (lap) state_nxt = RUN;
      end
      PAUSE: begin
        if (clear) begin
          state_nxt = IDLE;
          clear_all = 1'b1;
        end else if (start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      psc         <= '0;
      overflow    <= 1'b0;
      display_reg <= '0;
    end else begin
      if (clear_all) begin
        count    <= '0;
        psc      <= '0;
        overflow <= 1'b0;
      end else begin
        if (running) psc <= tick ? '0 : psc + PSC_W'(1);
        if (tick) begin
          count <= count_inc;
          if (wrap) overflow <= 1'b1;
        end
      end
      // Captures the pre-increment value when tick coincides with lap.
      if (lap_capture) display_reg <= count;
    end
  end

endmodule
